// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: funct3 encodings, FSM states and sizing shared by the RV32M multiply/divide unit
package muldiv_unit_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = $clog2(XLEN);
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: decode-to-execute handshake for M-extension ops (start/kill in, busy/done/result out)
interface muldiv_unit_if #(parameter int N = 32);
  logic start;
  logic kill;
  logic [2:0] funct3;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic busy;
  logic done;
  logic [N-1:0] result;
  modport master(output start, kill, funct3, op_a, op_b, input busy, done, result);
  modport slave(input start, kill, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit_div_restore_step.sv
// div_restore_step: one combinational restoring-division step producing one quotient bit
module div_restore_step #(parameter int N = 32) (
  input  logic [N-1:0] rem_in,
  input  logic [N-1:0] quo_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic [N-1:0] quo_out
);
  logic [N:0] r, d;
  always_comb begin
    r = {rem_in, quo_in[N-1]};
    d = r - {1'b0, divisor};
    rem_out = d[N] ? r[N-1:0] : d[N-1:0];
    quo_out = {quo_in[N-2:0], ~d[N]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with busy stall, done pulse and kill abort.
// Define MULDIV_FAST_MUL_EN to resolve MUL* ops in one cycle through a registered 2N multiplier.
module muldiv_unit import muldiv_unit_pkg::*; #(parameter int N = XLEN) (
  input logic clock,
  input logic reset,
  muldiv_unit_if.slave m
);
  localparam int CW = $clog2(N);
  state_t state;
  md_op_t op, f;
  logic [2*N-1:0] acc, prod_fix;
  logic [N-1:0] opb, result, abs_a, abs_b, special_res, quick_res, rem_next, quo_next, hi, lo, fix_res;
  logic [N:0] sum;
  logic [CW-1:0] cnt;
  logic neg, busy, done, sa, sb, is_div, ovf, special, quick;
  always_comb begin
    f = md_op_t'(m.funct3);
    sa = m.op_a[N-1] & (f == MD_MULH || f == MD_MULHSU || f == MD_DIV || f == MD_REM);
    sb = m.op_b[N-1] & (f == MD_MULH || f == MD_DIV || f == MD_REM);
    abs_a = sa ? -m.op_a : m.op_a;
    abs_b = sb ? -m.op_b : m.op_b;
    is_div = m.funct3[2];
    ovf = !m.funct3[0] && m.op_a == {1'b1, {(N-1){1'b0}}} && &m.op_b;
    special = is_div && (m.op_b == '0 || ovf);
    special_res = m.op_b == '0 ? (m.funct3[1] ? m.op_a : '1) : (m.funct3[1] ? '0 : m.op_a);
  end
`ifdef MULDIV_FAST_MUL_EN
  logic [2*N-1:0] fast_prod;
  assign fast_prod = $signed({{N{sa}}, m.op_a}) * $signed({{N{sb}}, m.op_b});
  assign quick = special || !is_div;
  assign quick_res = is_div ? special_res : (f == MD_MUL ? fast_prod[N-1:0] : fast_prod[2*N-1:N]);
`else
  assign quick = special;
  assign quick_res = special_res;
`endif
  // acc holds {partial product high, multiplier} for multiply and {remainder, dividend/quotient} for divide
  div_restore_step #(.N(N)) u_step (
    .rem_in(acc[2*N-1:N]),
    .quo_in(acc[N-1:0]),
    .divisor(opb),
    .rem_out(rem_next),
    .quo_out(quo_next)
  );
  assign sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opb} : '0);
  assign prod_fix = neg ? -acc : acc;
  assign hi = neg ? -acc[2*N-1:N] : acc[2*N-1:N];
  assign lo = neg ? -acc[N-1:0] : acc[N-1:0];
  assign fix_res = op[2] ? (op[1] ? hi : lo) : (op == MD_MUL ? prod_fix[N-1:0] : prod_fix[2*N-1:N]);
  assign m.busy = busy;
  assign m.done = done;
  assign m.result = result;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op <= MD_MUL;
      acc <= '0;
      opb <= '0;
      cnt <= '0;
      neg <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else if (m.kill) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (m.start) begin
          op <= f;
          busy <= 1'b1;
          if (quick) begin
            state <= DONE;
            done <= 1'b1;
            result <= quick_res;
          end else begin
            state <= CALC;
            acc <= {{N{1'b0}}, abs_a};
            opb <= abs_b;
            cnt <= CW'(N - 1);
            neg <= (f == MD_REM) ? sa : sa ^ sb;
          end
        end
        CALC: begin
          acc <= op[2] ? {rem_next, quo_next} : {sum, acc[N-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          state <= DONE;
          done <= 1'b1;
          result <= fix_res;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
`timescale 1ns/1ps
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  muldiv_unit_if #(.N(32)) bus ();
  muldiv_unit #(.N(32)) dut (.clock(clk), .reset(rst), .m(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    bit ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = 64'(a) * 64'(b); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'(b); return p[63:32]; end
      3'd3: begin p = 64'(a) * 64'(b); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4)
      return (b == 0 || (f[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 34;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit poke = 1'b0);
    logic [31:0] exp;
    int lat, k, idle;
    exp = model(f, a, b);
    lat = latency(f, a, b);
    k = 0;
    idle = 0;
    bus.funct3 = f;
    bus.op_a = a;
    bus.op_b = b;
    bus.start = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (!bus.busy) idle++;
      bus.start = poke && k == 5;
      if (poke && k == 5) begin
        bus.funct3 = ~f;
        bus.op_a = ~a;
        bus.op_b = b + 32'd1;
      end
    end while (!bus.done && k < 60);
    check({tag, "_latency"}, k, lat);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_busy_low_in_flight"}, idle, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
    check({tag, "_result_held"}, bus.result, exp);
  endtask

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0] f;
    int dones;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.funct3 = 3'd0;
    bus.op_a = 32'd0;
    bus.op_b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, "mul");
    run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(MD_DIV, 32'hFFFF_FFEC, 32'd3, "div_neg");
    run_op(MD_REM, 32'hFFFF_FFEC, 32'd3, "rem_neg");
    run_op(MD_DIVU, 32'd100, 32'd7, "divu");
    run_op(MD_REMU, 32'd100, 32'd7, "remu");
    run_op(MD_DIV, 32'd5, 32'd0, "div_by_zero");
    run_op(MD_REM, 32'd5, 32'd0, "rem_by_zero");
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    // kill mid-operation: aborts at once, no done pulse, result untouched
    prev = bus.result;
    bus.funct3 = MD_DIVU;
    bus.op_a = 32'd1000;
    bus.op_b = 32'd3;
    bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy", {31'b0, bus.busy}, 32'd0);
    check("kill_done", {31'b0, bus.done}, 32'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("kill_no_done", dones, 0);
    check("kill_result_kept", bus.result, prev);
    run_op(MD_DIVU, 32'd9, 32'd2, "divu_after_kill");
    // kill together with start: start is dropped
    bus.funct3 = MD_DIV;
    bus.op_a = 32'd5;
    bus.op_b = 32'd0;
    bus.start = 1'b1;
    bus.kill = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill = 1'b0;
    check("kill_start_busy", {31'b0, bus.busy}, 32'd0);
    check("kill_start_done", {31'b0, bus.done}, 32'd0);
    run_op(MD_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, "start_while_busy", 1'b1);
    run_op(MD_REM, 32'h8765_4321, 32'h0000_0123, "rem_while_busy", 1'b1);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(f, a, b, $sformatf("rand%0d_f%0d", i, f));
    end
    // reset in the middle of a calculation returns outputs to reset values
    bus.funct3 = MD_MULHU;
    bus.op_a = 32'hFFFF_0000;
    bus.op_b = 32'h0001_FFFF;
    bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midreset_busy", {31'b0, bus.busy}, 32'd0);
    check("midreset_done", {31'b0, bus.done}, 32'd0);
    check("midreset_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(MD_DIV, 32'hFFFF_FF9C, 32'd7, "div_after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
